// File: rtl/lynx_pkg.sv
// lynx_pkg: shared error/throttle enums and packet field-position helpers for the Lynx sink
// Ports: none (package).
package lynx_pkg;
  typedef enum logic [1:0] {NONE = 2'd0, MISROUTE = 2'd1, BAD_ID = 2'd2, SEQ = 2'd3} err_e;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} thr_e;
  function automatic int src_pos(int w, int a);
    return w - 1;
  endfunction
  function automatic int dst_pos(int w, int a);
    return w - 1 - a;
  endfunction
  function automatic int id_pos(int w, int a);
    return w - 1 - 2 * a;
  endfunction
  function automatic int cw(int w, int a);
    return w - 2 * a - 8;
  endfunction
endpackage

// File: rtl/ora_seq_checker_if.sv
// ora_seq_checker_if: NoC packet handshake between an upstream source and the sequence checker
// Signals: data_in (packet), valid_in (packet valid), ready_out (sink accept strobe).
interface ora_seq_checker_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  modport master (output data_in, valid_in, input ready_out);
  modport slave (input data_in, valid_in, output ready_out);
endinterface

// File: rtl/ora_seq_table.sv
// ora_seq_table: per-source expected-sequence register file, every entry resets to 1
// Ports: clk, rst, rd_id_i -> rd_data_o (combinational read), we_i/wr_id_i/wr_data_i (write).
module ora_seq_table
  import lynx_pkg::*;
#(
  parameter int NUM_IDS = 4,
  parameter int CW      = 16,
  parameter int IW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_id_i,
  output logic [CW-1:0] rd_data_o,
  input  logic          we_i,
  input  logic [IW-1:0] wr_id_i,
  input  logic [CW-1:0] wr_data_i
);
  logic [CW-1:0] mem_q [NUM_IDS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IDS; i++) mem_q[i] <= CW'(1);
    end else if (we_i) begin
      mem_q[wr_id_i] <= wr_data_i;
    end
  end
  assign rd_data_o = mem_q[rd_id_i];
endmodule

// File: rtl/ora_seq_checker.sv
// ora_seq_checker: NoC terminal sink checking routing and per-source sequence, with programmable backpressure
// Ports: clk, rst, bus (slave handshake), rx_count, err_count, err_sticky, last_err, done.
module ora_seq_checker
  import lynx_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 15,
  parameter int NUM_IDS      = 4,
  parameter int DONE_COUNT   = 1000,
  parameter int STALL_EVERY  = 0,
  parameter int STALL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  ora_seq_checker_if.slave    bus,
  output logic [31:0]         rx_count,
  output logic [15:0]         err_count,
  output logic                err_sticky,
  output logic [1:0]          last_err,
  output logic                done
);
  localparam int A       = N_ADDR_WIDTH;
  localparam int SRC_POS = src_pos(WIDTH, A);
  localparam int DST_POS = dst_pos(WIDTH, A);
  localparam int ID_POS  = id_pos(WIDTH, A);
  localparam int CW      = cw(WIDTH, A);
  localparam int IW      = NUM_IDS > 1 ? $clog2(NUM_IDS) : 1;
  logic [A-1:0]  src, dst;
  logic [7:0]    id;
  logic [CW-1:0] cnt, exp_v;
  err_e          code;
  logic          acc, hit, we;
  logic [31:0]   rx_q, rx_d, beat_q, beat_d, stall_q, stall_d;
  logic [15:0]   errc_q, errc_d;
  err_e          last_q, last_d;
  logic          sticky_q, sticky_d, done_q, done_d, ready_q, ready_d;
  thr_e          state_q, state_d;
  logic          unused_src;
  assign src        = bus.data_in[SRC_POS -: A];
  assign dst        = bus.data_in[DST_POS -: A];
  assign id         = bus.data_in[ID_POS -: 8];
  assign cnt        = bus.data_in[CW-1:0];
  assign unused_src = ^src;
  ora_seq_table #(.NUM_IDS(NUM_IDS), .CW(CW), .IW(IW)) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_id_i   (id[IW-1:0]),
    .rd_data_o (exp_v),
    .we_i      (we),
    .wr_id_i   (id[IW-1:0]),
    .wr_data_i (cnt + CW'(1))
  );
  // A resync on SEQ and a normal advance both leave exp = cnt + 1, so one write value serves both.
  always_comb begin
    acc      = bus.valid_in && ready_q;
    code     = dst != A'(NODE) ? MISROUTE : 32'(id) >= NUM_IDS ? BAD_ID : cnt != exp_v ? SEQ : NONE;
    hit      = acc && code != NONE;
    we       = acc && (code == NONE || code == SEQ);
    rx_d     = acc ? rx_q + 32'd1 : rx_q;
    errc_d   = hit && errc_q != 16'hFFFF ? errc_q + 16'd1 : errc_q;
    last_d   = hit ? code : last_q;
    sticky_d = sticky_q | hit;
    done_d   = done_q | (rx_q >= 32'(DONE_COUNT));
  end
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    if (state_q == RUN) begin
      if (acc) beat_d = beat_q + 32'd1;
      if (acc && STALL_EVERY != 0 && beat_q + 32'd1 == 32'(STALL_EVERY)) begin
        beat_d  = '0;
        stall_d = '0;
        state_d = STALL;
      end
    end else if (stall_q == 32'(STALL_CYCLES - 1)) begin
      state_d = RUN;
    end else begin
      stall_d = stall_q + 32'd1;
    end
    ready_d = state_d == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q     <= '0;
      errc_q   <= '0;
      last_q   <= NONE;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
      state_q  <= RUN;
      beat_q   <= '0;
      stall_q  <= '0;
    end else begin
      rx_q     <= rx_d;
      errc_q   <= errc_d;
      last_q   <= last_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
    end
  end
  assign bus.ready_out = ready_q;
  assign rx_count      = rx_q;
  assign err_count     = errc_q;
  assign err_sticky    = sticky_q;
  assign last_err      = last_q;
  assign done          = done_q;
endmodule
